// File: rtl/dcfifo_wr_ctrl.sv
// rtl/dcfifo_wr_ctrl.sv - tick-triggered burst writer for the dual-clock FIFO write port
module dcfifo_wr_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 16,
    parameter int SKIP_W    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              tick_in,
    input  logic              wr_full,
    input  logic              wr_empty,
    output logic              wr_req,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [SKIP_W-1:0] skip_cnt
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic              s1, s2, s3;
    logic              tick_rise;
    logic              beat_clr;
    logic              skip_inc;
    logic [DATA_W-1:0] data_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    // Preset to 1 so a tick already high when reset releases is not seen as an edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            {s1, s2, s3} <= 3'b111;
        end else begin
            {s1, s2, s3} <= {tick_in, s1, s2};
        end
    end

    assign tick_rise = s2 & ~s3;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        busy      = 1'b0;
        beat_clr  = 1'b0;
        skip_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (tick_rise) begin
                    if (wr_empty) begin
                        beat_clr  = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        skip_inc = 1'b1;
                    end
                end
            end
            WRITE: begin
                busy     = 1'b1;
                wr_req   = ~wr_full;
                skip_inc = tick_rise;
                if (wr_req && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // data_cnt runs across bursts; only reset brings it back to zero
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_cnt <= '0;
            beat_cnt <= '0;
            skip_cnt <= '0;
        end else begin
            if (beat_clr) begin
                beat_cnt <= '0;
            end else if (wr_req) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (wr_req) begin
                data_cnt <= data_cnt + 1'b1;
            end
            if (skip_inc && (skip_cnt != '1)) begin
                skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end

    assign wr_data = data_cnt;

endmodule

// File: tb/tb_dcfifo_wr_ctrl.sv
// tb/tb_dcfifo_wr_ctrl.sv - randomized and directed bench for dcfifo_wr_ctrl
module tb_dcfifo_wr_ctrl;

    localparam int DW       = 8;
    localparam int BL       = 16;
    localparam int SW       = 2;
    localparam int SKIP_MAX = (1 << SW) - 1;

    logic          sys_clk  = 1'b0;
    logic          sys_rst  = 1'b1;
    logic          tick_in  = 1'b0;
    logic          wr_full  = 1'b0;
    logic          wr_empty = 1'b1;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic [SW-1:0] skip_cnt;

    dcfifo_wr_ctrl #(
        .DATA_W   (DW),
        .BURST_LEN(BL),
        .SKIP_W   (SW)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .tick_in (tick_in),
        .wr_full (wr_full),
        .wr_empty(wr_empty),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .busy    (busy),
        .skip_cnt(skip_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks    = 0;
    int fails     = 0;
    int cyc       = 0;
    int first_req = -1;
    int seen[$];

    // Reference: burst in progress with words left, next data value, skip tally,
    // and the history of tick_in samples (three ones after reset).
    bit m_valid = 1'b0;
    bit m_busy  = 1'b0;
    int m_left  = 0;
    int m_data  = 0;
    int m_skip  = 0;
    bit tq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge sys_clk) begin
        bit rise;
        cyc++;
        if (sys_rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_left  = 0;
            m_data  = 0;
            m_skip  = 0;
            tq      = {1'b1, 1'b1, 1'b1};
        end else begin
            rise = tq[$-1] && !tq[$-2];
            if (m_busy) begin
                if (!wr_full) begin
                    m_data = (m_data + 1) % (1 << DW);
                    m_left--;
                    if (m_left == 0) m_busy = 1'b0;
                end
                if (rise && m_skip < SKIP_MAX) m_skip++;
            end else if (rise) begin
                if (wr_empty) begin
                    m_busy = 1'b1;
                    m_left = BL;
                end else if (m_skip < SKIP_MAX) begin
                    m_skip++;
                end
            end
            tq.push_back(tick_in);
            if (tq.size() > 4) void'(tq.pop_front());
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("wr_req", 32'(wr_req), 32'(m_busy && !wr_full));
            chk("wr_data", 32'(wr_data), 32'(m_data));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("skip_cnt", 32'(skip_cnt), 32'(m_skip));
            if (wr_req === 1'b1) begin
                seen.push_back(int'(wr_data));
                if (first_req < 0) first_req = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic rstep(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
            wr_full = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        tick_in = 1'b1;
        step(hi);
        tick_in = 1'b0;
        step(lo);
    endtask

    task automatic do_reset();
        sys_rst  = 1'b1;
        tick_in  = 1'b0;
        wr_full  = 1'b0;
        wr_empty = 1'b1;
        step(2);
        sys_rst = 1'b0;
        step(4);
        seen.delete();
        first_req = -1;
    endtask

    int t0;

    initial begin
        step(1);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_skip", 32'(skip_cnt), 0);

        do_reset();
        t0 = cyc;
        pulse(4, 25);
        chk("single_words", seen.size(), 16);
        chk("single_first", seen[0], 0);
        chk("single_last", seen[15], 15);
        chk("single_latency", first_req - t0, 3);
        chk("single_skip", 32'(skip_cnt), 0);

        do_reset();
        tick_in = 1'b1;
        step(3);
        tick_in = 1'b0;
        step(4);
        wr_full = 1'b1;
        step(2);
        chk("bp_hold_data", 32'(wr_data), 4);
        chk("bp_hold_req", 32'(wr_req), 0);
        step(4);
        wr_full = 1'b0;
        step(25);
        chk("bp_words", seen.size(), 16);
        chk("bp_word4", seen[4], 4);
        chk("bp_last", seen[15], 15);

        do_reset();
        wr_empty = 1'b0;
        pulse(4, 6);
        chk("ne_skip", 32'(skip_cnt), 1);
        chk("ne_words", seen.size(), 0);
        wr_empty = 1'b1;
        pulse(4, 25);
        chk("ne_burst_words", seen.size(), 16);
        chk("ne_burst_first", seen[0], 0);

        do_reset();
        wr_full = 1'b1;
        pulse(4, 4);
        pulse(4, 4);
        chk("tdb_skip", 32'(skip_cnt), 1);
        chk("tdb_busy", 32'(busy), 1);
        wr_full = 1'b0;
        step(25);
        chk("tdb_words", seen.size(), 16);
        chk("tdb_busy_end", 32'(busy), 0);

        do_reset();
        wr_empty = 1'b0;
        repeat (5) pulse(4, 4);
        chk("sat_skip", 32'(skip_cnt), 3);
        wr_empty = 1'b1;

        do_reset();
        repeat (17) pulse(4, 20);
        chk("wrap_words", seen.size(), 272);
        chk("wrap_255", seen[255], 255);
        chk("wrap_256", seen[256], 0);
        chk("wrap_last", seen[271], 15);

        do_reset();
        tick_in = 1'b1;
        step(3);
        tick_in = 1'b0;
        step(7);
        sys_rst = 1'b1;
        tick_in = 1'b1;
        step(1);
        chk("midrst_req", 32'(wr_req), 0);
        chk("midrst_data", 32'(wr_data), 0);
        step(1);
        sys_rst = 1'b0;
        seen.delete();
        step(10);
        chk("midrst_noburst", seen.size(), 0);
        tick_in = 1'b0;
        step(4);
        pulse(4, 25);
        chk("midrst_words", seen.size(), 16);
        chk("midrst_first", seen[0], 0);

        do_reset();
        repeat (60) begin
            wr_empty = ($urandom_range(0, 3) != 0);
            tick_in  = 1'b1;
            rstep($urandom_range(3, 12));
            tick_in = 1'b0;
            rstep($urandom_range(3, 30));
            if ($urandom_range(0, 19) == 0) do_reset();
        end
        wr_full = 1'b0;
        step(40);
        chk("final_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
